// File: rtl/serial_code_pkg.sv
// rtl/serial_code_pkg.sv - state encoding, symbol codes and frame tables for serial_code_tx
package serial_code_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [1:0] SYM_NONE = 2'd0;
    localparam logic [1:0] SYM_A    = 2'd1;
    localparam logic [1:0] SYM_B    = 2'd2;
    localparam logic [1:0] SYM_C    = 2'd3;

    // Frames are left-aligned in 5 bits; unused tail bits are 0.
    localparam logic [4:0] FRAME_A = 5'b10100;
    localparam logic [4:0] FRAME_B = 5'b10010;
    localparam logic [4:0] FRAME_C = 5'b10000;

    localparam logic [2:0] LEN_A = 3'd3;
    localparam logic [2:0] LEN_B = 3'd4;
    localparam logic [2:0] LEN_C = 3'd5;

    function automatic logic [4:0] frame_bits(input logic [1:0] s);
        logic [4:0] f;
        f = 5'b00000;
        case (s)
            SYM_A:   f = FRAME_A;
            SYM_B:   f = FRAME_B;
            SYM_C:   f = FRAME_C;
            default: f = 5'b00000;
        endcase
        return f;
    endfunction

    function automatic logic [2:0] frame_len(input logic [1:0] s);
        logic [2:0] n;
        n = 3'd0;
        case (s)
            SYM_A:   n = LEN_A;
            SYM_B:   n = LEN_B;
            SYM_C:   n = LEN_C;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/serial_code_tx.sv
// rtl/serial_code_tx.sv - serial prefix-code transmitter with one-deep holding register
module serial_code_tx
    import serial_code_pkg::*;
#(
    parameter int unsigned GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sym,
    input  logic       valid,
    output logic       ready,
    output logic       a,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e     state_q;
    logic [4:0] shift_q;
    logic [2:0] cnt_q;
    logic [3:0] gap_q;
    logic       hold_v_q;
    logic [1:0] hold_sym_q;
    logic       a_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;

    logic       accept;
    logic       legal_acc;
    logic       frame_end;
    logic       load_d;
    logic [1:0] load_sym_d;
    logic [4:0] load_bits_d;
    logic [2:0] load_len_d;

    assign ready     = !hold_v_q;
    assign accept    = valid && ready;
    assign legal_acc = accept && (sym != SYM_NONE);

    // Edge at which the line is free for a new frame next cycle; a waiting
    // symbol (held, or arriving right now) is loaded without a bubble.
    always_comb begin
        frame_end = 1'b0;
        case (state_q)
            ST_IDLE: frame_end = 1'b1;
            ST_SEND: frame_end = (cnt_q == 3'd0) && (GAP == 0);
            ST_GAP:  frame_end = (gap_q == 4'd0);
            default: frame_end = 1'b1;
        endcase
    end

    assign load_d      = frame_end && (hold_v_q || legal_acc);
    assign load_sym_d  = hold_v_q ? hold_sym_q : sym;
    assign load_bits_d = frame_bits(load_sym_d);
    assign load_len_d  = frame_len(load_sym_d);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= 5'b00000;
            cnt_q      <= 3'd0;
            gap_q      <= 4'd0;
            hold_v_q   <= 1'b0;
            hold_sym_q <= SYM_NONE;
            a_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= accept && (sym == SYM_NONE);
            if (load_d) begin
                state_q  <= ST_SEND;
                a_q      <= load_bits_d[4];
                shift_q  <= load_bits_d << 1;
                cnt_q    <= load_len_d - 3'd1;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
                hold_v_q <= 1'b0;
            end else begin
                if (legal_acc) begin
                    hold_v_q   <= 1'b1;
                    hold_sym_q <= sym;
                end
                case (state_q)
                    ST_IDLE: begin
                        a_q    <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                    ST_SEND: begin
                        if (cnt_q != 3'd0) begin
                            a_q     <= shift_q[4];
                            shift_q <= shift_q << 1;
                            cnt_q   <= cnt_q - 3'd1;
                            done_q  <= (cnt_q == 3'd1);
                        end else if (GAP != 0) begin
                            state_q <= ST_GAP;
                            a_q     <= 1'b0;
                            done_q  <= 1'b0;
                            gap_q   <= 4'(GAP - 1);
                        end else begin
                            state_q <= ST_IDLE;
                            a_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        a_q    <= 1'b0;
                        done_q <= 1'b0;
                        if (gap_q != 4'd0) begin
                            gap_q <= gap_q - 4'd1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        a_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign a    = a_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_serial_code_tx.sv
// tb/tb_serial_code_tx.sv - randomized self-checking bench for serial_code_tx (GAP=0 and GAP=2)
module tb_serial_code_tx;

    localparam int GAP0 = 0;
    localparam int GAP1 = 2;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [1:0] sym;
    logic [1:0] rdy, ln, bsy, dn, er;

    serial_code_tx #(.GAP(GAP0)) dut0 (
        .clk(clk), .rst(rst), .sym(sym), .valid(valid),
        .ready(rdy[0]), .a(ln[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0])
    );

    serial_code_tx #(.GAP(GAP1)) dut1 (
        .clk(clk), .rst(rst), .sym(sym), .valid(valid),
        .ready(rdy[1]), .a(ln[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference: a FIFO of scheduled line items (bit0=a, bit1=done, bit2=busy).
    int         fq    [2][16];
    int         flen  [2];
    logic       hv    [2];
    logic [1:0] hs    [2];
    int         cur   [2];
    logic       merr  [2];
    int         gaps  [2];

    logic [31:0] tr [2];
    logic [31:0] td [2];
    logic [31:0] te [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_item(input int k, input int item);
        fq[k][flen[k]] = item;
        flen[k] = flen[k] + 1;
    endtask

    task automatic push_frame(input int k, input logic [1:0] s);
        int len;
        int b;
        len = int'(s) + 2;
        for (int i = 0; i < len; i++) begin
            b = (i == 0 || (i == len - 1 && s != 2'd3)) ? 1 : 0;
            push_item(k, 4 | ((i == len - 1) ? 2 : 0) | b);
        end
        for (int g = 0; g < gaps[k]; g++) push_item(k, 4);
    endtask

    task automatic model_step(input int k, input logic v, input logic [1:0] s, input logic r);
        logic acc;
        logic legal;
        if (!r) begin
            flen[k] = 0;
            hv[k]   = 1'b0;
            cur[k]  = 0;
            merr[k] = 1'b0;
            return;
        end
        acc   = v && !hv[k];
        legal = acc && (s != 2'd0);
        merr[k] = acc && (s == 2'd0);
        if (flen[k] == 0) begin
            if (hv[k]) begin
                push_frame(k, hs[k]);
                hv[k] = 1'b0;
            end else if (legal) begin
                push_frame(k, s);
            end
        end else if (legal) begin
            hv[k] = 1'b1;
            hs[k] = s;
        end
        if (flen[k] > 0) begin
            cur[k] = fq[k][0];
            for (int i = 0; i < 15; i++) fq[k][i] = fq[k][i+1];
            flen[k] = flen[k] - 1;
        end else begin
            cur[k] = 0;
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] s, input logic r);
        valid = v;
        sym   = s;
        rst   = r;
        for (int k = 0; k < 2; k++) model_step(k, v, s, r);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("a%0d", k),     32'(ln[k]),  32'(cur[k] & 1));
            check($sformatf("done%0d", k),  32'(dn[k]),  32'((cur[k] >> 1) & 1));
            check($sformatf("busy%0d", k),  32'(bsy[k]), 32'((cur[k] >> 2) & 1));
            check($sformatf("err%0d", k),   32'(er[k]),  32'(merr[k]));
            check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!hv[k]));
            tr[k] = {tr[k][30:0], ln[k]};
            td[k] = {td[k][30:0], dn[k]};
            te[k] = {te[k][30:0], er[k]};
        end
    endtask

    task automatic clear_traces();
        for (int k = 0; k < 2; k++) begin
            tr[k] = '0;
            td[k] = '0;
            te[k] = '0;
        end
    endtask

    initial begin
        logic       v;
        logic [1:0] s;
        logic       r;
        n_chk   = 0;
        n_fail  = 0;
        gaps[0] = GAP0;
        gaps[1] = GAP1;
        for (int k = 0; k < 2; k++) begin
            flen[k] = 0; hv[k] = 1'b0; hs[k] = 2'd0; cur[k] = 0; merr[k] = 1'b0;
        end
        clear_traces();
        rst   = 1'b0;
        valid = 1'b1;
        sym   = 2'd1;
        @(negedge clk);

        cycle(1'b1, 2'd1, 1'b0);
        cycle(1'b1, 2'd1, 1'b0);

        clear_traces();
        cycle(1'b1, 2'd1, 1'b1);
        repeat (5) cycle(1'b0, 2'd0, 1'b1);
        check("single_a",    tr[0], 32'b101000);
        check("single_done", td[0], 32'b001000);

        clear_traces();
        cycle(1'b1, 2'd2, 1'b1);
        cycle(1'b1, 2'd3, 1'b1);
        repeat (11) cycle(1'b0, 2'd0, 1'b1);
        check("b2b_a", tr[0], 32'b1001100000000);

        clear_traces();
        cycle(1'b1, 2'd1, 1'b1);
        cycle(1'b1, 2'd1, 1'b1);
        repeat (10) cycle(1'b0, 2'd0, 1'b1);
        check("gap_a", tr[1], 32'b101001010000);

        clear_traces();
        cycle(1'b1, 2'd0, 1'b1);
        cycle(1'b0, 2'd0, 1'b1);
        check("illegal_err", te[0], 32'b10);
        check("illegal_a",   tr[0], 32'b00);

        clear_traces();
        cycle(1'b1, 2'd3, 1'b1);
        cycle(1'b1, 2'd1, 1'b1);
        cycle(1'b0, 2'd0, 1'b0);
        repeat (8) cycle(1'b0, 2'd0, 1'b1);
        check("abort_a", tr[0], 32'b10000000000);

        repeat (40) cycle(1'b1, 2'($urandom_range(1, 3)), 1'b1);

        repeat (4000) begin
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            cycle(v, s, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
